imm_decode_stage: RTL and testbench
===================================

// Module: imm_decode_stage
// PURPOSE
//  Instruction decode front stage of the 32-bit RV32I core. Accepts instr/PC from fetch over
//  valid/ready, classifies the opcode into a 3-bit immediate format select, and forms the
//  32-bit immediate through the existing 8-input 32-bit mux (Mux_8to1, 3-bit sel).
//  Holds results in a 2-entry skid buffer and presents them registered to execute.
//  Full throughput of 1 instr/cycle.
// PARAMETERS
//  XLEN   32  datapath / immediate width
//  PC_W   32  program counter width
// PORTS
//  clk            in   1      core clock, rising edge
//  rst            in   1      reset, synchronous, active-high
//  flush          in   1      pipeline flush (branch mispredict / trap), synchronous
//  in_valid       in   1      fetch presents instr
//  in_ready       out  1      stage can accept this cycle
//  in_instr       in   32     raw instruction
//  in_pc          in   PC_W   instruction PC
//  out_valid      out  1      decoded entry available
//  out_ready      in   1      execute accepts entry
//  out_instr      out  32     instruction of head entry
//  out_pc         out  PC_W   PC of head entry
//  out_imm        out  XLEN   formatted immediate
//  out_imm_sel    out  3      immediate format code (below)
//  out_illegal    out  1      unknown opcode or instr[1:0]!=2'b11
// BEHAVIOUR
//  Imm sel: 000 I sext(i[31:20]); 001 S sext{i[31:25],i[11:7]}; 010 B sext{i[31],i[7],i[30:25],i[11:8],0};
//   011 U {i[31:12],12'b0}; 100 J sext{i[31],i[19:12],i[20],i[30:21],0}; 101 SHAMT zext(i[24:20]);
//   110 ZIMM zext(i[19:15]); 111 NONE -> 32'd0.
//  Opcode map: OP-IMM 0010011 -> I, except funct3 001/101 -> SHAMT; LOAD 0000011, JALR 1100111,
//   FENCE 0001111 -> I; STORE 0100011 -> S; BRANCH 1100011 -> B; LUI 0110111, AUIPC 0010111 -> U;
//   JAL 1101111 -> J; SYSTEM 1110011 -> ZIMM if funct3[2] else I; OP 0110011 -> NONE;
//   any other opcode, or i[1:0]!=11 -> NONE with illegal=1.
//  Decode is combinational on the input side; imm/sel/illegal are stored with the entry.
//  FSM: EMPTY, ONE (main valid), TWO (main+skid valid). in_fire=in_valid&in_ready; out_fire=out_valid&out_ready.
//   EMPTY: in_fire -> ONE, main<=input.
//   ONE: in_fire&out_fire -> ONE, main<=input; in_fire only -> TWO, skid<=input; out_fire only -> EMPTY.
//   TWO: no accept; out_fire -> ONE, main<=skid.
//  in_ready = (state!=TWO) & ~flush. out_valid = (state!=EMPTY). out_* driven from main regs only.
//  Latency: accepted in cycle N -> visible on out_* in cycle N+1 (EMPTY case). Order strictly FIFO.
//  Stall: while out_valid & ~out_ready all out_* hold stable.
//  flush (and rst): next cycle state=EMPTY, out_valid=0, in_ready=1; input in flush cycle is dropped.
//   rst has priority over flush; flush has priority over any accept/drain in the same cycle.
//  Reset values: out_valid=0, out_instr=0, out_pc=0, out_imm=0, out_imm_sel=3'b111, out_illegal=0.
//  Payload regs need not clear on flush; only valid/state must.
// STRUCTURE
//  Package rv_imm_pkg: localparams IMM_I..IMM_NONE (3-bit), RV32I opcode constants, state encoding.
//  Sub-module imm_sel_decode: combinational {instr} -> {imm_sel, illegal}.
//  Eight formatted candidates feed Mux_8to1 (a=I ... h=NONE) in this block; skid/FSM in top.
// TESTING
//  ADDI 0xFFF00093, out_ready=1 -> next cycle out_valid=1, imm_sel=000, imm=0xFFFFFFFF, illegal=0.
//  SW 0xFE112E23 -> imm_sel=001, imm=0xFFFFFFFC; LUI 0x12345037 -> sel=011, imm=0x12345000.
//  SLLI 0x00509093 -> sel=101, imm=0x00000005; instr 0x00000000 -> sel=111, imm=0, illegal=1.
//  out_ready=0, push A,B,C back-to-back -> A,B accepted, in_ready=0 on 3rd cycle, out_* = A held;
//   raise out_ready -> A,B,C emitted on consecutive cycles, in order, no loss/duplication.
//  State TWO, assert flush 1 cycle with in_valid=1 -> next cycle out_valid=0, in_ready=1, input dropped.
//  rst asserted mid-stream with flush=1 -> all outputs at reset values next cycle; 1/cycle streaming resumes.

Source files
------------

// File: rtl/rv_imm_pkg.sv
// Shared constants for the RV32I immediate decode stage: format codes, opcodes, FSM states.
package rv_imm_pkg;

  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_B     = 3'b010;
  localparam logic [2:0] IMM_U     = 3'b011;
  localparam logic [2:0] IMM_J     = 3'b100;
  localparam logic [2:0] IMM_SHAMT = 3'b101;
  localparam logic [2:0] IMM_ZIMM  = 3'b110;
  localparam logic [2:0] IMM_NONE  = 3'b111;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

endpackage

// File: rtl/imm_sel_decode.sv
// Classifies an RV32I opcode/funct3 into an immediate format code and an illegal flag.
module imm_sel_decode
  import rv_imm_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output logic [2:0] imm_sel,
  output logic       illegal
);

  always_comb begin
    imm_sel = IMM_NONE;
    illegal = 1'b0;
    if (opcode[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opcode)
        OPC_OP_IMM: imm_sel = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SHAMT : IMM_I;
        OPC_LOAD, OPC_JALR, OPC_FENCE: imm_sel = IMM_I;
        OPC_STORE:  imm_sel = IMM_S;
        OPC_BRANCH: imm_sel = IMM_B;
        OPC_LUI, OPC_AUIPC: imm_sel = IMM_U;
        OPC_JAL:    imm_sel = IMM_J;
        // CSR*I forms carry a 5-bit zero-extended immediate in rs1.
        OPC_SYSTEM: imm_sel = funct3[2] ? IMM_ZIMM : IMM_I;
        OPC_OP:     imm_sel = IMM_NONE;
        default:    illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mux_8to1.sv
// Generic 8-input mux shared across the core datapath.
module Mux_8to1 #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  input  logic [W-1:0] e,
  input  logic [W-1:0] f,
  input  logic [W-1:0] g,
  input  logic [W-1:0] h,
  input  logic [2:0]   sel,
  output logic [W-1:0] y
);

  always_comb begin
    unique case (sel)
      3'd0:    y = a;
      3'd1:    y = b;
      3'd2:    y = c;
      3'd3:    y = d;
      3'd4:    y = e;
      3'd5:    y = f;
      3'd6:    y = g;
      default: y = h;
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Decode front stage: forms the immediate from fetch input and buffers it in a 2-entry skid.
module imm_decode_stage
  import rv_imm_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_imm_sel,
  output logic            out_illegal
);

  logic [31:0]     i;
  logic [2:0]      dec_sel;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_shamt, imm_zimm, imm_none;

  assign i = in_instr;

  imm_sel_decode u_sel_decode (
    .opcode  (i[6:0]),
    .funct3  (i[14:12]),
    .imm_sel (dec_sel),
    .illegal (dec_illegal)
  );

  assign imm_i     = {{20{i[31]}}, i[31:20]};
  assign imm_s     = {{20{i[31]}}, i[31:25], i[11:7]};
  assign imm_b     = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  assign imm_u     = {i[31:12], 12'b0};
  assign imm_j     = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  assign imm_shamt = {27'b0, i[24:20]};
  assign imm_zimm  = {27'b0, i[19:15]};
  assign imm_none  = '0;

  Mux_8to1 #(.W(XLEN)) u_imm_mux (
    .a   (imm_i),
    .b   (imm_s),
    .c   (imm_b),
    .d   (imm_u),
    .e   (imm_j),
    .f   (imm_shamt),
    .g   (imm_zimm),
    .h   (imm_none),
    .sel (dec_sel),
    .y   (dec_imm)
  );

  state_e          state_q, state_d;
  logic            load_main_in, load_main_skid, load_skid;
  logic            in_fire, out_fire;

  logic [31:0]     skid_instr_q;
  logic [PC_W-1:0] skid_pc_q;
  logic [XLEN-1:0] skid_imm_q;
  logic [2:0]      skid_sel_q;
  logic            skid_illegal_q;

  assign in_ready  = (state_q != StTwo) & ~flush;
  assign out_valid = (state_q != StEmpty);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d      = StOne;
            load_main_in = 1'b1;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            state_d   = StTwo;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (out_fire) begin
            state_d        = StOne;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StEmpty;
      out_instr      <= '0;
      out_pc         <= '0;
      out_imm        <= '0;
      out_imm_sel    <= IMM_NONE;
      out_illegal    <= 1'b0;
      skid_instr_q   <= '0;
      skid_pc_q      <= '0;
      skid_imm_q     <= '0;
      skid_sel_q     <= IMM_NONE;
      skid_illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_main_in) begin
        out_instr   <= in_instr;
        out_pc      <= in_pc;
        out_imm     <= dec_imm;
        out_imm_sel <= dec_sel;
        out_illegal <= dec_illegal;
      end else if (load_main_skid) begin
        out_instr   <= skid_instr_q;
        out_pc      <= skid_pc_q;
        out_imm     <= skid_imm_q;
        out_imm_sel <= skid_sel_q;
        out_illegal <= skid_illegal_q;
      end
      if (load_skid) begin
        skid_instr_q   <= in_instr;
        skid_pc_q      <= in_pc;
        skid_imm_q     <= dec_imm;
        skid_sel_q     <= dec_sel;
        skid_illegal_q <= dec_illegal;
      end
    end
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: queue-based reference model plus directed pins.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [2:0]  out_imm_sel;
  logic        out_illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_imm     (out_imm),
    .out_imm_sel (out_imm_sel),
    .out_illegal (out_illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  sel;
    logic        ill;
  } ent_t;

  ent_t q[$];

  function automatic ent_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
    ent_t e;
    int   v;
    e.instr = ins;
    e.pc    = pc;
    e.ill   = 1'b0;
    e.sel   = 3'd7;
    if (ins[1:0] != 2'b11) e.ill = 1'b1;
    else begin
      case (ins[6:0])
        7'b0010011: e.sel = (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) ? 3'd5 : 3'd0;
        7'b0000011, 7'b1100111, 7'b0001111: e.sel = 3'd0;
        7'b0100011: e.sel = 3'd1;
        7'b1100011: e.sel = 3'd2;
        7'b0110111, 7'b0010111: e.sel = 3'd3;
        7'b1101111: e.sel = 3'd4;
        7'b1110011: e.sel = ins[14] ? 3'd6 : 3'd0;
        7'b0110011: e.sel = 3'd7;
        default:    e.ill = 1'b1;
      endcase
    end
    case (e.sel)
      3'd0:    v = $signed(ins[31:20]);
      3'd1:    v = $signed({ins[31:25], ins[11:7]});
      3'd2:    v = $signed({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2;
      3'd3:    v = int'(ins & 32'hFFFF_F000);
      3'd4:    v = $signed({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2;
      3'd5:    v = int'((ins >> 20) & 32'd31);
      3'd6:    v = int'((ins >> 15) & 32'd31);
      default: v = 0;
    endcase
    e.imm = v;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of depth 2, pop before push, cleared on rst/flush.
  always @(posedge clk) begin
    int n;
    n = q.size();
    if (rst || flush) q.delete();
    else begin
      if (n > 0 && out_ready) void'(q.pop_front());
      if (in_valid && n < 2) q.push_back(model_decode(in_instr, in_pc));
    end
  end

  always @(negedge clk) begin
    chk("in_ready", {31'b0, in_ready}, {31'b0, (q.size() < 2) && !flush});
    chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
    if (q.size() > 0) begin
      chk("out_instr", out_instr, q[0].instr);
      chk("out_pc", out_pc, q[0].pc);
      chk("out_imm", out_imm, q[0].imm);
      chk("out_imm_sel", {29'b0, out_imm_sel}, {29'b0, q[0].sel});
      chk("out_illegal", {31'b0, out_illegal}, {31'b0, q[0].ill});
    end
  end

  task automatic cyc(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                     input logic ordy, input logic fl, input logic r);
    #1;
    in_valid  = iv;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_instr"}, out_instr, 32'd0);
    chk({tag, "_pc"}, out_pc, 32'd0);
    chk({tag, "_imm"}, out_imm, 32'd0);
    chk({tag, "_sel"}, {29'b0, out_imm_sel}, 32'd7);
    chk({tag, "_illegal"}, {31'b0, out_illegal}, 32'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [12];
    logic [31:0] r;
    int          k;
    ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011, 7'b0110011, 7'b1011011};
    r = $urandom;
    k = $urandom_range(0, 13);
    if (k < 12) r[6:0] = ops[k];
    else if (k == 12) r[1:0] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  typedef struct {
    logic [31:0] ins;
    logic [31:0] imm;
    logic [2:0]  sel;
    logic        ill;
  } pin_t;

  initial begin
    pin_t pins[7];
    pins[0] = '{32'hFFF00093, 32'hFFFFFFFF, 3'd0, 1'b0};  // ADDI x1,x0,-1
    pins[1] = '{32'hFE112E23, 32'hFFFFFFFC, 3'd1, 1'b0};  // SW
    pins[2] = '{32'h12345037, 32'h12345000, 3'd3, 1'b0};  // LUI
    pins[3] = '{32'h00509093, 32'h00000005, 3'd5, 1'b0};  // SLLI
    pins[4] = '{32'h00000000, 32'h00000000, 3'd7, 1'b1};  // illegal
    pins[5] = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd2, 1'b0};  // BEQ -4
    pins[6] = '{32'hFF9FF06F, 32'hFFFFFFF8, 3'd4, 1'b0};  // JAL -8

    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk_reset_vals("rst0");
    chk("rst0_in_ready", {31'b0, in_ready}, 32'd1);

    foreach (pins[k]) begin
      ent_t m;
      m = model_decode(pins[k].ins, 0);
      chk("model_imm", m.imm, pins[k].imm);
      cyc(1, pins[k].ins, 32'h100 + 4 * k, 1, 0, 0);
      chk("pin_valid", {31'b0, out_valid}, 32'd1);
      chk("pin_imm", out_imm, pins[k].imm);
      chk("pin_sel", {29'b0, out_imm_sel}, {29'b0, pins[k].sel});
      chk("pin_illegal", {31'b0, out_illegal}, {31'b0, pins[k].ill});
    end
    cyc(0, 0, 0, 1, 0, 0);

    // Skid fill and drain
    cyc(1, 32'hAAAA0013, 32'h200, 0, 0, 0);
    cyc(1, 32'hBBBB0013, 32'h204, 0, 0, 0);
    chk("skid_full_ready", {31'b0, in_ready}, 32'd0);
    cyc(1, 32'hCCCC0013, 32'h208, 0, 0, 0);
    chk("skid_hold_instr", out_instr, 32'hAAAA0013);
    chk("skid_hold_ready", {31'b0, in_ready}, 32'd0);
    cyc(1, 32'hCCCC0013, 32'h208, 1, 0, 0);
    chk("drain_b", out_instr, 32'hBBBB0013);
    cyc(1, 32'hCCCC0013, 32'h208, 1, 0, 0);
    chk("drain_c", out_instr, 32'hCCCC0013);
    cyc(0, 0, 0, 1, 0, 0);
    chk("drain_empty", {31'b0, out_valid}, 32'd0);

    // Flush while full, with a live input
    cyc(1, 32'h11110013, 32'h300, 0, 0, 0);
    cyc(1, 32'h22220013, 32'h304, 0, 0, 0);
    cyc(1, 32'h33330013, 32'h308, 0, 1, 0);
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    #1;
    chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    chk("flush_dropped", {31'b0, out_valid}, 32'd0);

    // Reset mid-stream together with flush
    for (int k = 0; k < 4; k++) cyc(1, rand_instr(), $urandom, k[0], 0, 0);
    cyc(1, 32'h44440013, 32'h400, 1, 1, 1);
    chk_reset_vals("rst1");
    for (int k = 0; k < 3; k++) begin
      cyc(1, 32'h00100093 + (k << 20), 32'h500 + 4 * k, 1, 0, 0);
      chk("resume_instr", out_instr, 32'h00100093 + (k << 20));
    end

    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom_range(0, 3) != 0,
          $urandom_range(0, 63) == 0, $urandom_range(0, 255) == 0);
    end
    cyc(0, 0, 0, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
